spi_burst_ctrl: RTL and testbench
=================================

Name: spi_burst_ctrl

Overview:
- Transaction-level controller for the byte-wide SPI master engine in the sensor interface.
- Arbitrates between two requesters using round-robin, e.g. the heart-rate sampling FSM and the config/debug path.
- Sequences each winning request as a burst: command byte, address byte, then 0..MAX_LEN data bytes.
- Holds chip select low across the whole burst and enforces a minimum deselect gap between bursts.

Parameters:
- WORD, 8: SPI byte width.
- MAX_LEN, 4: maximum data bytes per burst.
- GAP, 2: number of refCLK cycles in the GAP state after each burst (chip select high).
- CMD_RD, 8'h0B: command byte for a register read.
- CMD_WR, 8'h0A: command byte for a register write.

Ports:
- refCLK  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- req  in  2  per-requester request level.
- req_rw  in  2  per requester: 1 = read, 0 = write.
- req_addr  in  2*WORD  register address; requester i uses slice [i*WORD +: WORD].
- req_len  in  2*$clog2(MAX_LEN+1)  data byte count per requester.
- req_wdata  in  2*MAX_LEN*WORD  write bytes per requester; byte 0 in the LSBs.
- grant  out  2  one-hot, one-cycle pulse: request captured.
- done  out  2  one-hot, one-cycle pulse: burst complete.
- rdata  out  MAX_LEN*WORD  read bytes; byte 0 in the LSBs.
- busy  out  1  high in any state other than IDLE.
- eng_start  out  1  one-cycle pulse: engine shifts eng_txd.
- eng_txd  out  WORD  byte to transmit; valid while eng_start is high.
- eng_hold  out  1  keeps the engine's SSN low between bytes.
- eng_done  in  1  one-cycle pulse: byte finished.
- eng_rxd  in  WORD  received byte; valid while eng_done is high.

Behaviour:
- Reset values: grant=0, done=0, rdata=0, busy=0, eng_start=0, eng_txd=0, eng_hold=0.
  - State returns to IDLE and the round-robin pointer gives requester 0 priority.
  - Reset mid-burst aborts immediately. No done is issued; eng_hold drops the next cycle.
- States: IDLE -> CMD -> WCMD -> ADDR -> WADDR -> {DATA -> WDATA}* -> FIN -> GAP -> IDLE.
- IDLE:
  - Any req high in cycle N: the winner's rw/addr/len/wdata are registered and grant[w] pulses in N+1.
  - State moves to CMD in N+1.
  - A requester may drop req after its grant. A req still high after done is treated as a new request.
- Arbitration:
  - If only one requester is high, it wins.
  - If both are high, the requester not served last wins.
  - The pointer updates on grant only.
- CMD:
  - eng_start=1 with eng_txd=CMD_RD or CMD_WR; eng_hold rises this cycle.
  - Next state WCMD, which waits for eng_done.
- ADDR/WADDR: same pattern with eng_txd=addr.
- Data phase:
  - Byte count is len, clamped to MAX_LEN when len > MAX_LEN.
  - len=0: go from WADDR directly to FIN.
  - Write: eng_txd = wdata byte i.
  - Read: eng_txd = 8'h00, and eng_rxd is stored into rdata byte i on eng_done.
  - Bytes with index >= len keep their previous rdata contents.
  - A 2-bit counter indexes bytes (for MAX_LEN=4). After the last eng_done, go to FIN.
- Byte spacing: eng_start for byte i+1 occurs one cycle after eng_done of byte i. Never more than one eng_start is outstanding.
- FIN:
  - done[w]=1 for one cycle; eng_hold=0.
  - rdata is stable from the done cycle until the next read burst's first capture.
- GAP: stays exactly GAP cycles with no grant, then returns to IDLE.
  - GAP=0 goes straight from FIN to IDLE.
- Spurious eng_done outside the W* states is ignored.
- Write bursts leave rdata unchanged.

Test Plan:
- Single write: req[0], rw=0, addr=8'h2D, len=1, wdata=8'h02.
  - Expect grant[0] 1 cycle after req.
  - Engine sees starts with 0A, 2D, 02; eng_hold high across all three; done[0] one cycle after the 3rd eng_done; busy low after GAP=2 cycles.
- Read burst: req[1], rw=1, addr=8'h0E, len=4, engine returns 11,22,33,44.
  - Expect eng_txd sequence 0B,0E,00,00,00,00 and rdata=32'h44332211 at done[1].
- Simultaneous requests after reset: req=2'b11.
  - Expect grant order 0, 1, 0 over three back-to-back bursts with req held high.
  - Exactly one eng_hold high→low transition per burst, followed by a ≥GAP-cycle low period.
- Boundaries:
  - len=0 write: only 2 engine bytes, then done.
  - len=7 (clamped): exactly 6 engine bytes.
  - Stray eng_done in IDLE: no state change.
- Reset mid-burst: assert reset in WDATA of byte 1.
  - Next cycle: eng_hold=0, busy=0, no done pulse.
  - A following req[1] with both requesters high is granted to requester 0 first.

Source files
------------

// File: rtl/spi_burst_ctrl_if.sv
// Requester-side and SPI-engine-side signals of the burst controller.
// The controller connects through the slave modport; the driving side uses master.
interface spi_burst_ctrl_if #(
   parameter int WORD    = 8,
   parameter int MAX_LEN = 4
);
   localparam int LW = $clog2(MAX_LEN + 1);

   logic [1:0]                  req;
   logic [1:0]                  req_rw;
   logic [2*WORD-1:0]           req_addr;
   logic [2*LW-1:0]             req_len;
   logic [2*MAX_LEN*WORD-1:0]   req_wdata;
   logic [1:0]                  grant;
   logic [1:0]                  done;
   logic [MAX_LEN*WORD-1:0]     rdata;
   logic                        busy;
   logic                        eng_start;
   logic [WORD-1:0]             eng_txd;
   logic                        eng_hold;
   logic                        eng_done;
   logic [WORD-1:0]             eng_rxd;

   modport master (
      output req, req_rw, req_addr, req_len, req_wdata, eng_done, eng_rxd,
      input  grant, done, rdata, busy, eng_start, eng_txd, eng_hold
   );

   modport slave (
      input  req, req_rw, req_addr, req_len, req_wdata, eng_done, eng_rxd,
      output grant, done, rdata, busy, eng_start, eng_txd, eng_hold
   );
endinterface

// File: rtl/spi_burst_ctrl.sv
// Round-robin SPI burst sequencer: command, address and up to MAX_LEN data bytes
// per grant, chip select held across the burst, then a fixed deselect gap.
module spi_burst_ctrl #(
   parameter int              WORD    = 8,
   parameter int              MAX_LEN = 4,
   parameter int              GAP     = 2,
   parameter logic [WORD-1:0] CMD_RD  = 8'h0B,
   parameter logic [WORD-1:0] CMD_WR  = 8'h0A
) (
   input  logic             refCLK,
   input  logic             reset,
   spi_burst_ctrl_if.slave  bus
);
   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int CW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int BW = MAX_LEN * WORD;

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_WCMD, S_ADDR, S_WADDR, S_DATA, S_WDATA, S_FIN, S_GAP
   } state_e;

   state_e          state_q, state_d;
   logic            last_q, last_d;
   logic            win_q, win_d;
   logic [1:0]      grant_q, grant_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [BW-1:0]   rdata_q, rdata_d;
   logic            rw_q;
   logic [WORD-1:0] addr_q;
   logic [LW-1:0]   len_q;
   logic [BW-1:0]   wdata_q;
   logic            win;
   logic [LW-1:0]   len_raw;
   logic            last_byte;

   // With both requesters pending, the one not served last wins
   always_comb begin
      win = 1'b0;
      if (bus.req == 2'b10)      win = 1'b1;
      else if (bus.req == 2'b11) win = ~last_q;
   end

   assign len_raw   = win ? bus.req_len[LW +: LW] : bus.req_len[0 +: LW];
   assign last_byte = ((LW'(cnt_q) + LW'(1)) == len_q);

   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      win_d         = win_q;
      grant_d       = '0;
      cnt_d         = cnt_q;
      gap_d         = gap_q;
      rdata_d       = rdata_q;
      bus.eng_start = 1'b0;
      bus.eng_txd   = '0;
      bus.eng_hold  = 1'b0;
      bus.done      = '0;
      case (state_q)
         S_IDLE: begin
            if (|bus.req) begin
               grant_d = win ? 2'b10 : 2'b01;
               last_d  = win;
               win_d   = win;
               state_d = S_CMD;
            end
         end
         S_CMD: begin
            bus.eng_start = 1'b1;
            bus.eng_txd   = rw_q ? CMD_RD : CMD_WR;
            bus.eng_hold  = 1'b1;
            state_d       = S_WCMD;
         end
         S_WCMD: begin
            bus.eng_hold = 1'b1;
            if (bus.eng_done) state_d = S_ADDR;
         end
         S_ADDR: begin
            bus.eng_start = 1'b1;
            bus.eng_txd   = addr_q;
            bus.eng_hold  = 1'b1;
            state_d       = S_WADDR;
         end
         S_WADDR: begin
            bus.eng_hold = 1'b1;
            if (bus.eng_done) begin
               cnt_d   = '0;
               state_d = (len_q == '0) ? S_FIN : S_DATA;
            end
         end
         S_DATA: begin
            bus.eng_start = 1'b1;
            bus.eng_txd   = rw_q ? '0 : wdata_q[cnt_q*WORD +: WORD];
            bus.eng_hold  = 1'b1;
            state_d       = S_WDATA;
         end
         S_WDATA: begin
            bus.eng_hold = 1'b1;
            if (bus.eng_done) begin
               if (rw_q) rdata_d[cnt_q*WORD +: WORD] = bus.eng_rxd;
               if (last_byte) begin
                  state_d = S_FIN;
               end else begin
                  cnt_d   = cnt_q + CW'(1);
                  state_d = S_DATA;
               end
            end
         end
         S_FIN: begin
            bus.done = win_q ? 2'b10 : 2'b01;
            gap_d    = '0;
            state_d  = (GAP == 0) ? S_IDLE : S_GAP;
         end
         S_GAP: begin
            if (gap_q == GW'(GAP - 1)) state_d = S_IDLE;
            else                       gap_d   = gap_q + GW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge refCLK) begin
      if (reset) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         win_q   <= 1'b0;
         grant_q <= '0;
         cnt_q   <= '0;
         gap_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         win_q   <= win_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         gap_q   <= gap_d;
         rdata_q <= rdata_d;
      end
   end

   // Request fields are captured once per grant and held for the whole burst
   always_ff @(posedge refCLK) begin
      if (state_q == S_IDLE && (|bus.req)) begin
         rw_q    <= bus.req_rw[win];
         addr_q  <= win ? bus.req_addr[WORD +: WORD] : bus.req_addr[0 +: WORD];
         len_q   <= (len_raw > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len_raw;
         wdata_q <= win ? bus.req_wdata[BW +: BW] : bus.req_wdata[0 +: BW];
      end
   end

   assign bus.grant = grant_q;
   assign bus.rdata = rdata_q;
   assign bus.busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed and randomized bursts against a byte-level engine responder and a
// transaction model of the expected SPI byte stream and read-data register.
module tb_spi_burst_ctrl;
   localparam int WORD    = 8;
   localparam int MAX_LEN = 4;
   localparam int GAP     = 2;
   localparam int LW      = $clog2(MAX_LEN + 1);

   logic refCLK = 1'b0;
   logic reset  = 1'b1;
   always #5 refCLK = ~refCLK;

   spi_burst_ctrl_if #(.WORD(WORD), .MAX_LEN(MAX_LEN)) bus ();

   spi_burst_ctrl #(
      .WORD(WORD), .MAX_LEN(MAX_LEN), .GAP(GAP), .CMD_RD(8'h0B), .CMD_WR(8'h0A)
   ) dut (
      .refCLK(refCLK), .reset(reset), .bus(bus)
   );

   int checks = 0;
   int passed = 0;
   int fails  = 0;
   int burst_id = 0;

   // Engine responder state and logs
   logic [7:0] tx_q[$];
   logic [7:0] rxlog[$];
   int         low_q[$];
   int         wait_c = -1;
   int         burst_bytes = 0;
   int         low_run = 0;
   int         hold_falls = 0;
   int         spacing_err = 0;
   int         hold_err = 0;
   int         overlap_err = 0;
   logic       prev_hold = 1'b0;
   logic       prev_done = 1'b0;
   int         abort_cnt = 0;
   int         abort_seen = 0;
   int         stray_cnt = 0;
   int         stray_seen = 0;
   bit         rx_mode = 1'b0;

   logic [31:0] rdata_m = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s (burst %0d): observed %0h expected %0h", tag, burst_id, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge refCLK);
      #2;
   endtask

   initial begin
      bus.eng_done = 1'b0;
      bus.eng_rxd  = '0;
      forever begin
         @(posedge refCLK);
         #1;
         prev_done    = bus.eng_done;
         bus.eng_done = 1'b0;
         if (abort_cnt != abort_seen) begin
            abort_seen = abort_cnt;
            wait_c     = -1;
         end
         if (bus.eng_hold) begin
            if (!prev_hold) low_q.push_back(low_run);
            low_run = 0;
         end else begin
            if (prev_hold) hold_falls++;
            low_run++;
            burst_bytes = 0;
         end
         prev_hold = bus.eng_hold;
         if (bus.eng_start) begin
            if (wait_c >= 0) overlap_err++;
            if (!bus.eng_hold) hold_err++;
            if (burst_bytes > 0 && !prev_done) spacing_err++;
            burst_bytes++;
            tx_q.push_back(bus.eng_txd);
            wait_c = $urandom_range(0, 2);
         end else if (wait_c > 0) begin
            wait_c--;
         end else if (wait_c == 0) begin
            bus.eng_done = 1'b1;
            bus.eng_rxd  = rx_mode ? 8'(8'h11 * (burst_bytes - 2)) : 8'($urandom);
            rxlog.push_back(bus.eng_rxd);
            wait_c = -1;
         end else if (stray_cnt != stray_seen) begin
            stray_seen   = stray_cnt;
            bus.eng_done = 1'b1;
            bus.eng_rxd  = 8'($urandom);
         end
      end
   end

   task automatic set_req(input int i, input bit rw, input logic [7:0] a, input int len,
                          input logic [31:0] wd);
      bus.req_rw[i]             = rw;
      bus.req_addr[i*8 +: 8]    = a;
      bus.req_len[i*LW +: LW]   = LW'(len);
      bus.req_wdata[i*32 +: 32] = wd;
      bus.req[i]                = 1'b1;
   endtask

   task automatic wait_grant(output logic [1:0] g);
      g = '0;
      for (int k = 0; k < 64; k++) begin
         tick();
         if (bus.grant != 2'b00) begin
            g = bus.grant;
            return;
         end
      end
   endtask

   task automatic wait_done(output logic [1:0] d);
      d = '0;
      for (int k = 0; k < 400; k++) begin
         tick();
         if (bus.done != 2'b00) begin
            d = bus.done;
            return;
         end
      end
   endtask

   // One complete single-requester burst, checked against the transaction model
   task automatic run_burst(input int i, input bit rw, input logic [7:0] a, input int len,
                            input logic [31:0] wd);
      int         n;
      int         tx_base;
      int         rx_base;
      logic [1:0] d;
      logic [7:0] e;
      burst_id++;
      n       = (len > MAX_LEN) ? MAX_LEN : len;
      tx_base = tx_q.size();
      rx_base = rxlog.size();
      set_req(i, rw, a, len, wd);
      tick();
      check("grant", 64'(bus.grant), (i == 1) ? 64'd2 : 64'd1);
      bus.req[i] = 1'b0;
      wait_done(d);
      check("done", 64'(d), (i == 1) ? 64'd2 : 64'd1);
      check("tx_count", 64'(tx_q.size() - tx_base), 64'(n + 2));
      for (int k = 0; k < n + 2 && tx_base + k < tx_q.size(); k++) begin
         if (k == 0)      e = rw ? 8'h0B : 8'h0A;
         else if (k == 1) e = a;
         else             e = rw ? 8'h00 : wd[(k-2)*8 +: 8];
         check("txd", 64'(tx_q[tx_base + k]), 64'(e));
      end
      if (rw) begin
         for (int j = 0; j < n; j++)
            if (rx_base + 2 + j < rxlog.size()) rdata_m[j*8 +: 8] = rxlog[rx_base + 2 + j];
      end
      check("rdata", 64'(bus.rdata), 64'(rdata_m));
      tick();
      tick();
      check("busy_in_gap", 64'(bus.busy), 64'd1);
      tick();
      check("busy_after_gap", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      logic [1:0] g;
      logic [1:0] d;
      int         falls0;
      int         low0;
      int         tx0;
      logic [31:0] rd_snap;

      bus.req = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_len = '0; bus.req_wdata = '0;
      reset = 1'b1;
      tick(); tick();
      check("rst_grant", 64'(bus.grant), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_rdata", 64'(bus.rdata), 64'd0);
      check("rst_ctrl", 64'({bus.busy, bus.eng_start, bus.eng_hold}), 64'd0);
      check("rst_txd", 64'(bus.eng_txd), 64'd0);
      reset = 1'b0;
      tick();

      run_burst(0, 1'b0, 8'h2D, 1, 32'h0000_0002);

      rx_mode = 1'b1;
      run_burst(1, 1'b1, 8'h0E, 4, 32'($urandom));
      check("rd_bytes", 64'(bus.rdata), 64'h4433_2211);
      rx_mode = 1'b0;

      run_burst(0, 1'b0, 8'($urandom), 0, 32'($urandom));
      run_burst(1, 1'b1, 8'($urandom), 7, 32'($urandom));
      run_burst(0, 1'b0, 8'($urandom), 6, 32'($urandom));

      for (int r = 0; r < 6; r++)
         run_burst(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                   int'($urandom_range(0, 7)), 32'($urandom));

      // Stray engine completion while idle
      rd_snap = bus.rdata;
      stray_cnt++;
      tick(); tick();
      check("stray_busy", 64'(bus.busy), 64'd0);
      check("stray_start", 64'(bus.eng_start), 64'd0);
      tick();
      check("stray_idle", 64'({bus.busy, bus.eng_hold}), 64'd0);
      check("stray_rdata", 64'(bus.rdata), 64'(rd_snap));

      // Back-to-back arbitration from a fresh reset with both requesters held
      burst_id++;
      reset = 1'b1;
      tick(); tick();
      reset   = 1'b0;
      rdata_m = '0;
      tick();
      falls0 = hold_falls;
      low0   = low_q.size();
      set_req(0, 1'b0, 8'($urandom), int'($urandom_range(0, 4)), 32'($urandom));
      set_req(1, 1'b0, 8'($urandom), int'($urandom_range(0, 4)), 32'($urandom));
      for (int b = 0; b < 3; b++) begin
         wait_grant(g);
         check("rr_grant", 64'(g), (b == 1) ? 64'd2 : 64'd1);
         if (b == 2) bus.req = '0;
         wait_done(d);
         check("rr_done", 64'(d), 64'(g));
      end
      for (int k = 0; k < 6; k++) tick();
      check("rr_hold_falls", 64'(hold_falls - falls0), 64'd3);
      check("rr_hold_rises", 64'(low_q.size() - low0), 64'd3);
      for (int k = low0 + 1; k < low_q.size(); k++)
         check("rr_gap_low", 64'(low_q[k] >= GAP), 64'd1);

      // Abort a write burst during the wait for data byte 1
      burst_id++;
      tx0 = tx_q.size();
      set_req(0, 1'b0, 8'($urandom), 3, 32'($urandom));
      tick();
      check("abort_grant", 64'(bus.grant), 64'd1);
      bus.req = '0;
      for (int k = 0; k < 100 && tx_q.size() < tx0 + 4; k++) tick();
      check("abort_reached", 64'(tx_q.size() >= tx0 + 4), 64'd1);
      tick();
      reset = 1'b1;
      tick();
      check("abort_hold", 64'(bus.eng_hold), 64'd0);
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_done", 64'(bus.done), 64'd0);
      reset = 1'b0;
      abort_cnt++;
      rdata_m = '0;
      set_req(0, 1'b0, 8'($urandom), 1, 32'($urandom));
      set_req(1, 1'b0, 8'($urandom), 1, 32'($urandom));
      tick();
      check("abort_ptr_grant", 64'(bus.grant), 64'd1);
      bus.req = '0;
      wait_done(d);
      check("abort_next_done", 64'(d), 64'd1);
      for (int k = 0; k < 6; k++) tick();

      check("overlap_err", 64'(overlap_err), 64'd0);
      check("hold_err", 64'(hold_err), 64'd0);
      check("spacing_err", 64'(spacing_err), 64'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
      $fatal(1, "watchdog expired");
   end
endmodule
